dispatch_stage: RTL and testbench

- 2-wide dispatch stage between rename and the ALU issue queue; the transmitting end of the issue-queue dispatch interface.
- Registers one renamed bundle per cycle and compacts it so lane 0 is always filled first.
- Computes per-operand ready bits from a physical-register busy table plus same-cycle writeback bypass.
- Drives the issue-queue dispatch enables, which are never gated by anything that depends on those enables.

---
 rtl/dispatch_stage.sv | 169 ++++++++++++++++
 tb/tb_dispatch_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_stage
// Purpose  : 2-wide rename-to-issue-queue dispatch with lane compaction,
//            busy-table operand readiness and writeback bypass.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_stage #(
    parameter int DISPATCH_WIDTH       = 2,
    parameter int PHYS_REGS            = 64,
    parameter int PHYS_REGS_ADDR_WIDTH = 6,
    parameter int ROB_ADDR_WIDTH       = 4,
    parameter int DISPATCH_ADDR_WIDTH  = 1,
    parameter int ALU_CMD_WIDTH        = 4,
    parameter int OP_TYPE_WIDTH        = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [DISPATCH_WIDTH-1:0]                             in_valid,
    output logic                                                  in_ready,
    input  logic [DISPATCH_WIDTH-1:0][ALU_CMD_WIDTH-1:0]          in_alu_cmd,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   in_op1,
    input  logic [DISPATCH_WIDTH-1:0][31:0]                       in_op2,
    input  logic [DISPATCH_WIDTH-1:0][OP_TYPE_WIDTH-1:0]          in_op2_type,
    input  logic [DISPATCH_WIDTH-1:0]                             in_rd_valid,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   in_phys_rd,
    input  logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]    in_bank_addr,
    input  logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]         in_rob_addr,
    input  logic                                                  isq_full,
    output logic [DISPATCH_WIDTH-1:0]                             disp_en,
    output logic [DISPATCH_WIDTH-1:0][ALU_CMD_WIDTH-1:0]          disp_alu_cmd,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   disp_op1,
    output logic [DISPATCH_WIDTH-1:0][31:0]                       disp_op2,
    output logic [DISPATCH_WIDTH-1:0][OP_TYPE_WIDTH-1:0]          disp_op2_type,
    output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   disp_phys_rd,
    output logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]    disp_bank_addr,
    output logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]         disp_rob_addr,
    output logic [DISPATCH_WIDTH-1:0]                             disp_op1_valid,
    output logic [DISPATCH_WIDTH-1:0]                             disp_op2_valid,
    input  logic [DISPATCH_WIDTH-1:0]                             wb_valid,
    input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   wb_phys_rd
);

    localparam logic [OP_TYPE_WIDTH-1:0] c_OP_REG = OP_TYPE_WIDTH'(0);
    localparam logic [OP_TYPE_WIDTH-1:0] c_OP_IMM = OP_TYPE_WIDTH'(1);

    logic [DISPATCH_WIDTH-1:0]                           r_hold_valid;
    logic [DISPATCH_WIDTH-1:0][ALU_CMD_WIDTH-1:0]        r_alu_cmd;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] r_op1;
    logic [DISPATCH_WIDTH-1:0][31:0]                     r_op2;
    logic [DISPATCH_WIDTH-1:0][OP_TYPE_WIDTH-1:0]        r_op2_type;
    logic [DISPATCH_WIDTH-1:0]                           r_rd_valid;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] r_phys_rd;
    logic [DISPATCH_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]  r_bank_addr;
    logic [DISPATCH_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]       r_rob_addr;
    logic [PHYS_REGS-1:0]                                r_ready;

    logic                      w_fire;
    logic                      w_accept;
    logic                      w_lane0_writes;
    logic                      w_op1_hit;
    logic                      w_op2_hit;
    logic [PHYS_REGS-1:0]      w_ready_nxt;
    logic [DISPATCH_WIDTH-1:0] w_op1_valid;
    logic [DISPATCH_WIDTH-1:0] w_op2_valid;

    // Enables depend only on held state and isq_full, never on their own effect.
    assign w_fire   = (|r_hold_valid) && !isq_full && !rst;
    assign in_ready = !(|r_hold_valid) || w_fire;
    assign w_accept = (|in_valid) && in_ready;
    assign disp_en  = r_hold_valid & {DISPATCH_WIDTH{!isq_full && !rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= '0;
            r_alu_cmd    <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_op2_type   <= '0;
            r_rd_valid   <= '0;
            r_phys_rd    <= '0;
            r_bank_addr  <= '0;
            r_rob_addr   <= '0;
        end else if (w_accept) begin
            r_hold_valid <= in_valid;
            r_alu_cmd    <= in_alu_cmd;
            r_op1        <= in_op1;
            r_op2        <= in_op2;
            r_op2_type   <= in_op2_type;
            r_rd_valid   <= in_rd_valid;
            r_phys_rd    <= in_phys_rd;
            r_bank_addr  <= in_bank_addr;
            r_rob_addr   <= in_rob_addr;
            // A lone lane-1 instruction is moved down so lane 0 is always filled first.
            if (in_valid == 2'b10) begin
                r_hold_valid   <= 2'b01;
                r_alu_cmd[0]   <= in_alu_cmd[1];
                r_op1[0]       <= in_op1[1];
                r_op2[0]       <= in_op2[1];
                r_op2_type[0]  <= in_op2_type[1];
                r_rd_valid[0]  <= in_rd_valid[1];
                r_phys_rd[0]   <= in_phys_rd[1];
                r_bank_addr[0] <= in_bank_addr[1];
                r_rob_addr[0]  <= in_rob_addr[1];
            end
        end else if (w_fire) begin
            r_hold_valid <= '0;
        end
    end

    // Sets are applied before clears so a same-cycle clear wins; p0 is always ready.
    always_comb begin
        w_ready_nxt = r_ready;
        for (int b = 0; b < DISPATCH_WIDTH; b++) begin
            if (wb_valid[b]) w_ready_nxt[wb_phys_rd[b]] = 1'b1;
        end
        if (w_fire) begin
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (r_hold_valid[i] && r_rd_valid[i] && (r_phys_rd[i] != '0))
                    w_ready_nxt[r_phys_rd[i]] = 1'b0;
            end
        end
        w_ready_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_ready <= '1;
        else     r_ready <= w_ready_nxt;
    end

    assign w_lane0_writes = r_hold_valid[0] && r_rd_valid[0] && (r_phys_rd[0] != '0);

    // Readiness is qualified by lane valid so empty lanes report not-ready.
    always_comb begin
        w_op1_valid = '0;
        w_op2_valid = '0;
        w_op1_hit   = 1'b0;
        w_op2_hit   = 1'b0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            w_op1_hit = r_ready[r_op1[i]];
            w_op2_hit = r_ready[r_op2[i][PHYS_REGS_ADDR_WIDTH-1:0]];
            for (int b = 0; b < DISPATCH_WIDTH; b++) begin
                if (wb_valid[b] && (wb_phys_rd[b] == r_op1[i])) w_op1_hit = 1'b1;
                if (wb_valid[b] && (wb_phys_rd[b] == r_op2[i][PHYS_REGS_ADDR_WIDTH-1:0]))
                    w_op2_hit = 1'b1;
            end
            if ((i != 0) && w_lane0_writes) begin
                if (r_phys_rd[0] == r_op1[i]) w_op1_hit = 1'b0;
                if (r_phys_rd[0] == r_op2[i][PHYS_REGS_ADDR_WIDTH-1:0]) w_op2_hit = 1'b0;
            end
            w_op1_valid[i] = r_hold_valid[i] && w_op1_hit;
            if (r_op2_type[i] == c_OP_IMM)      w_op2_valid[i] = r_hold_valid[i];
            else if (r_op2_type[i] == c_OP_REG) w_op2_valid[i] = r_hold_valid[i] && w_op2_hit;
            else                                w_op2_valid[i] = 1'b0;
        end
    end

    assign disp_alu_cmd   = r_alu_cmd;
    assign disp_op1       = r_op1;
    assign disp_op2       = r_op2;
    assign disp_op2_type  = r_op2_type;
    assign disp_phys_rd   = r_phys_rd;
    assign disp_bank_addr = r_bank_addr;
    assign disp_rob_addr  = r_rob_addr;
    assign disp_op1_valid = w_op1_valid;
    assign disp_op2_valid = w_op2_valid;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_stage
// Purpose  : Directed and randomized checks of dispatch_stage against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_stage;

    localparam logic [1:0] c_T_REG = 2'd0;
    localparam logic [1:0] c_T_IMM = 2'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      in_valid;
    logic            in_ready;
    logic [1:0][3:0] in_alu_cmd;
    logic [1:0][5:0] in_op1;
    logic [1:0][31:0] in_op2;
    logic [1:0][1:0] in_op2_type;
    logic [1:0]      in_rd_valid;
    logic [1:0][5:0] in_phys_rd;
    logic [1:0][0:0] in_bank_addr;
    logic [1:0][3:0] in_rob_addr;
    logic            isq_full;
    logic [1:0]      disp_en;
    logic [1:0][3:0] disp_alu_cmd;
    logic [1:0][5:0] disp_op1;
    logic [1:0][31:0] disp_op2;
    logic [1:0][1:0] disp_op2_type;
    logic [1:0][5:0] disp_phys_rd;
    logic [1:0][0:0] disp_bank_addr;
    logic [1:0][3:0] disp_rob_addr;
    logic [1:0]      disp_op1_valid;
    logic [1:0]      disp_op2_valid;
    logic [1:0]      wb_valid;
    logic [1:0][5:0] wb_phys_rd;

    dispatch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_cmd(in_alu_cmd), .in_op1(in_op1), .in_op2(in_op2),
        .in_op2_type(in_op2_type), .in_rd_valid(in_rd_valid),
        .in_phys_rd(in_phys_rd), .in_bank_addr(in_bank_addr),
        .in_rob_addr(in_rob_addr), .isq_full(isq_full),
        .disp_en(disp_en), .disp_alu_cmd(disp_alu_cmd), .disp_op1(disp_op1),
        .disp_op2(disp_op2), .disp_op2_type(disp_op2_type),
        .disp_phys_rd(disp_phys_rd), .disp_bank_addr(disp_bank_addr),
        .disp_rob_addr(disp_rob_addr), .disp_op1_valid(disp_op1_valid),
        .disp_op2_valid(disp_op2_valid), .wb_valid(wb_valid),
        .wb_phys_rd(wb_phys_rd)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one held bundle and a free/busy flag per physical register.
    logic [1:0]       m_hv;
    logic [1:0][3:0]  m_alu;
    logic [1:0][5:0]  m_op1;
    logic [1:0][31:0] m_op2;
    logic [1:0][1:0]  m_type;
    logic [1:0]       m_rdv;
    logic [1:0][5:0]  m_rd;
    logic [1:0][0:0]  m_bank;
    logic [1:0][3:0]  m_rob;
    bit               m_free[64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit src_ready(input logic [5:0] p);
        return (p == 6'd0) || m_free[p] ||
               (wb_valid[0] && wb_phys_rd[0] == p) || (wb_valid[1] && wb_phys_rd[1] == p);
    endfunction

    function automatic bit model_in_ready();
        bit busy = |m_hv;
        return !busy || (busy && !isq_full && !rst);
    endfunction

    task automatic model_reset();
        m_hv = '0; m_alu = '0; m_op1 = '0; m_op2 = '0; m_type = '0;
        m_rdv = '0; m_rd = '0; m_bank = '0; m_rob = '0;
        for (int r = 0; r < 64; r++) m_free[r] = 1'b1;
    endtask

    task automatic settle_check();
        logic [1:0] e_en, e_o1, e_o2;
        bit dep, h1, h2;
        #2;
        e_en = rst ? 2'b00 : (m_hv & {2{!isq_full}});
        for (int i = 0; i < 2; i++) begin
            dep = (i == 1) && m_hv[0] && m_rdv[0] && (m_rd[0] != 0);
            h1 = src_ready(m_op1[i]) && !(dep && m_rd[0] == m_op1[i]);
            h2 = src_ready(m_op2[i][5:0]) && !(dep && m_rd[0] == m_op2[i][5:0]);
            e_o1[i] = m_hv[i] && h1;
            case (m_type[i])
                c_T_IMM: e_o2[i] = m_hv[i];
                c_T_REG: e_o2[i] = m_hv[i] && h2;
                default: e_o2[i] = 1'b0;
            endcase
        end
        chk("in_ready", in_ready, model_in_ready());
        chk("disp_en", disp_en, e_en);
        chk("op1_valid", disp_op1_valid, e_o1);
        chk("op2_valid", disp_op2_valid, e_o2);
        chk("alu_cmd", disp_alu_cmd, m_alu);
        chk("op1", disp_op1, m_op1);
        chk("op2", disp_op2, m_op2);
        chk("op2_type", disp_op2_type, m_type);
        chk("phys_rd", disp_phys_rd, m_rd);
        chk("bank", disp_bank_addr, m_bank);
        chk("rob", disp_rob_addr, m_rob);
    endtask

    task automatic advance();
        bit fire, acc;
        bit nfree[64];
        fire = (|m_hv) && !isq_full && !rst;
        acc  = (|in_valid) && model_in_ready();
        nfree = m_free;
        for (int b = 0; b < 2; b++) if (wb_valid[b]) nfree[wb_phys_rd[b]] = 1'b1;
        if (fire)
            for (int i = 0; i < 2; i++)
                if (m_hv[i] && m_rdv[i] && m_rd[i] != 0) nfree[m_rd[i]] = 1'b0;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_free = nfree;
            if (acc) begin
                m_alu = in_alu_cmd; m_op1 = in_op1; m_op2 = in_op2; m_type = in_op2_type;
                m_rdv = in_rd_valid; m_rd = in_phys_rd; m_bank = in_bank_addr; m_rob = in_rob_addr;
                m_hv  = in_valid;
                if (in_valid == 2'b10) begin
                    m_hv = 2'b01;
                    m_alu[0] = in_alu_cmd[1]; m_op1[0] = in_op1[1]; m_op2[0] = in_op2[1];
                    m_type[0] = in_op2_type[1]; m_rdv[0] = in_rd_valid[1]; m_rd[0] = in_phys_rd[1];
                    m_bank[0] = in_bank_addr[1]; m_rob[0] = in_rob_addr[1];
                end
            end else if (fire) begin
                m_hv = 2'b00;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_lane(input int l, input logic [5:0] op1, input logic [5:0] rd,
                            input logic rdv, input logic [1:0] typ, input logic [3:0] rob);
        in_alu_cmd[l]   = 4'(l + 3);
        in_op1[l]       = op1;
        in_op2[l]       = 32'h100 + 32'(l);
        in_op2_type[l]  = typ;
        in_rd_valid[l]  = rdv;
        in_phys_rd[l]   = rd;
        in_bank_addr[l] = 1'(l);
        in_rob_addr[l]  = rob;
    endtask

    task automatic cyc();
        settle_check();
        advance();
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; isq_full = 1'b0; wb_valid = '0; wb_phys_rd = '0;
        in_alu_cmd = '0; in_op1 = '0; in_op2 = '0; in_op2_type = '0;
        in_rd_valid = '0; in_phys_rd = '0; in_bank_addr = '0; in_rob_addr = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        cyc();
        rst = 1'b0;
        settle_check();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_disp_en", disp_en, 2'b00);
        advance();

        // 1: full bundle, both immediates, rd p5/p6
        in_valid = 2'b11;
        set_lane(0, 6'd1, 6'd5, 1'b1, c_T_IMM, 4'd0);
        set_lane(1, 6'd2, 6'd6, 1'b1, c_T_IMM, 4'd1);
        cyc();
        in_valid = 2'b00;
        settle_check();
        chk("t1_en", disp_en, 2'b11);
        chk("t1_op1v", disp_op1_valid, 2'b11);
        chk("t1_op2v", disp_op2_valid, 2'b11);
        advance();

        // 2: p5 is busy now; then bypass through writeback
        in_valid = 2'b01;
        set_lane(0, 6'd5, 6'd0, 1'b0, c_T_IMM, 4'd2);
        cyc();
        settle_check();
        chk("t2_busy", disp_op1_valid[0], 1'b0);
        advance();
        in_valid = 2'b00; wb_valid = 2'b01; wb_phys_rd[0] = 6'd5;
        settle_check();
        chk("t2_bypass", disp_op1_valid[0], 1'b1);
        advance();
        wb_valid = 2'b00;

        // 3: intra-bundle dependency, then with rd=p0
        in_valid = 2'b11;
        set_lane(0, 6'd3, 6'd7, 1'b1, c_T_IMM, 4'd4);
        set_lane(1, 6'd7, 6'd8, 1'b1, c_T_IMM, 4'd5);
        cyc();
        in_valid = 2'b00;
        settle_check();
        chk("t3_dep", disp_op1_valid[1], 1'b0);
        advance();
        in_valid = 2'b11;
        set_lane(0, 6'd3, 6'd0, 1'b1, c_T_IMM, 4'd4);
        set_lane(1, 6'd0, 6'd0, 1'b0, c_T_IMM, 4'd5);
        cyc();
        in_valid = 2'b00;
        settle_check();
        chk("t3_p0", disp_op1_valid[1], 1'b1);
        advance();

        // 4: lane-1-only bundle compacts to lane 0
        in_valid = 2'b10;
        set_lane(1, 6'd1, 6'd0, 1'b0, c_T_IMM, 4'd3);
        cyc();
        in_valid = 2'b00;
        settle_check();
        chk("t4_en", disp_en, 2'b01);
        chk("t4_rob", disp_rob_addr[0], 4'd3);
        advance();

        // 5: stall for 3 cycles, then release with back-to-back accept
        in_valid = 2'b11;
        set_lane(0, 6'd1, 6'd10, 1'b1, c_T_REG, 4'd6);
        set_lane(1, 6'd2, 6'd11, 1'b1, c_T_REG, 4'd7);
        cyc();
        in_valid = 2'b00; isq_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle_check();
            chk("t5_en", disp_en, 2'b00);
            chk("t5_rdy", in_ready, 1'b0);
            chk("t5_rob", disp_rob_addr, {4'd7, 4'd6});
            advance();
        end
        isq_full = 1'b0; in_valid = 2'b11;
        set_lane(0, 6'd1, 6'd0, 1'b0, c_T_IMM, 4'd8);
        set_lane(1, 6'd1, 6'd0, 1'b0, c_T_IMM, 4'd9);
        settle_check();
        chk("t5_rel_en", disp_en, 2'b11);
        chk("t5_rel_rdy", in_ready, 1'b1);
        advance();
        in_valid = 2'b00;
        settle_check();
        chk("t5_new", disp_rob_addr, {4'd9, 4'd8});
        advance();

        // 6: same-cycle clear and set of p9; clear must win
        in_valid = 2'b01;
        set_lane(0, 6'd1, 6'd9, 1'b1, c_T_IMM, 4'd10);
        cyc();
        in_valid = 2'b00; wb_valid = 2'b01; wb_phys_rd[0] = 6'd9;
        cyc();
        wb_valid = 2'b00; in_valid = 2'b01;
        set_lane(0, 6'd9, 6'd0, 1'b0, c_T_IMM, 4'd11);
        cyc();
        in_valid = 2'b00;
        settle_check();
        chk("t6_clr_wins", disp_op1_valid[0], 1'b0);
        advance();

        // 6b: reset during a stall
        in_valid = 2'b01;
        set_lane(0, 6'd9, 6'd12, 1'b1, c_T_IMM, 4'd12);
        cyc();
        in_valid = 2'b00; isq_full = 1'b1;
        cyc();
        rst = 1'b1;
        settle_check();
        chk("t6_rst_en", disp_en, 2'b00);
        advance();
        rst = 1'b0; isq_full = 1'b0;
        settle_check();
        chk("t6_after_en", disp_en, 2'b00);
        chk("t6_after_rdy", in_ready, 1'b1);
        advance();
        in_valid = 2'b01;
        set_lane(0, 6'd9, 6'd0, 1'b0, c_T_IMM, 4'd13);
        cyc();
        in_valid = 2'b00;
        settle_check();
        chk("t6_all_ready", disp_op1_valid[0], 1'b1);
        advance();

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            isq_full = ($urandom_range(0, 9) < 3);
            in_valid = 2'($urandom_range(0, 3));
            for (int l = 0; l < 2; l++) begin
                in_alu_cmd[l]   = 4'($urandom);
                in_op1[l]       = 6'($urandom_range(0, 15));
                in_op2[l]       = {26'($urandom), 6'($urandom_range(0, 15))};
                in_op2_type[l]  = 2'($urandom_range(0, 3));
                in_rd_valid[l]  = 1'($urandom);
                in_phys_rd[l]   = 6'($urandom_range(0, 15));
                in_bank_addr[l] = 1'($urandom);
                in_rob_addr[l]  = 4'($urandom);
                wb_valid[l]     = ($urandom_range(0, 3) == 0);
                wb_phys_rd[l]   = 6'($urandom_range(0, 15));
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
